acq_capture: RTL and testbench
==============================

# acq_capture

Triggered ADC-sample capture engine. It sits between an ADC AXI4-stream slave map (e.g. adc20/adc21) and the write port of an acquisition buffer BRAM (acqbuf0/acqbuf1), which the host reads over the lb3 bram controller. After an arm and a trigger, it writes a programmed number of optionally decimated stream beats into consecutive BRAM addresses starting at 0, then raises `done`.

## Interface
- `DATA_WIDTH`, 64: ADC stream beat width, equal to the BRAM data width.
- `ADDR_WIDTH`, 12: BRAM address width; maximum capture depth is 2^ADDR_WIDTH.
- `DECIM_WIDTH`, 8: width of the decimation control.

- `clk`  in  1  ADC stream clock; everything runs on it.
- `rst`  in  1  synchronous, active-high reset.
- `s_tvalid`  in  1  ADC stream valid.
- `s_tdata`  in  DATA_WIDTH  ADC stream data.
- `s_tready`  out  1  stream ready; the ADC is never back-pressured.
- `arm`  in  1  single-cycle pulse; starts waiting for a trigger.
- `trigger`  in  1  single-cycle pulse; starts the capture when armed.
- `abort`  in  1  single-cycle pulse; returns the block to IDLE.
- `decim`  in  DECIM_WIDTH  keep 1 beat out of every decim+1 accepted beats. Sampled at trigger.
- `nsamp`  in  ADDR_WIDTH  number of BRAM writes; 0 means 2^ADDR_WIDTH. Sampled at trigger.
- `bram_we`  out  1  BRAM write enable.
- `bram_addr`  out  ADDR_WIDTH  BRAM write address.
- `bram_din`  out  DATA_WIDTH  BRAM write data.
- `busy`  out  1  high in ARMED or CAPTURE.
- `done`  out  1  high in DONE.
- `gap`  out  1  sticky flag: `s_tvalid` was low during CAPTURE. Cleared by arm.

## Operation
- **States:** IDLE, ARMED, CAPTURE, DONE.
- **Transitions:**
  - IDLE or DONE, on `arm`: go to ARMED, clear `gap`.
  - ARMED, on `trigger`: go to CAPTURE. Latch `decim` and `nsamp`, zero the write address and the decimation counter.
  - CAPTURE, on the last write: go to DONE.
  - `abort` in any state: go to IDLE. It has priority over `arm` and `trigger` in the same cycle.
- **Ignored inputs:** `trigger` outside ARMED is ignored. `arm` during ARMED or CAPTURE is ignored.
- **Capture:** in CAPTURE each accepted beat (`s_tvalid & s_tready`) advances the decimation counter.
  - When the counter is 0, the beat is written to BRAM. The counter then increments and wraps to 0 after reaching the latched decim.
  - decim=0 writes every beat.
- **Addressing:** the write address increments by 1 per write. The capture ends after the latched nsamp writes, or 2^ADDR_WIDTH writes when nsamp=0. The address never wraps within a capture.
- **Gaps:** if `s_tvalid` is low in CAPTURE, no counters advance and `gap` is set.
- **Stream ready:** `s_tready` = !rst-registered (registered). It is 0 during reset and 1 otherwise. Beats outside CAPTURE are accepted and discarded.
- **Reset values:** state IDLE; `bram_we`, `bram_addr`, `bram_din`, `busy`, `done`, `gap` all 0; `s_tready` 0 in the cycle after `rst`.

## Timing
- **Write latency:** the BRAM write outputs are registered. A beat accepted at edge N appears with `bram_we`=1 and its address and data in the cycle after edge N.
- **First captured beat:** `trigger` sampled at edge T puts the block in CAPTURE after T. The first beat eligible for capture is the one accepted at edge T+1, so the beat coincident with `trigger` is not captured.
- **End of capture:** the state becomes DONE at the same edge that registers the last write. `done` and the final `bram_we` are high in the same cycle.
- **Back-to-back use:** `arm` in the first DONE cycle is legal.
- **Abort mid-capture:** `abort` at edge A drives `bram_we` to 0 from the cycle after A. No further writes occur, and `done` is not asserted.
- **Reset mid-capture:** same as abort, and all outputs return to their reset values.
- **Simultaneous events:** `arm` and `trigger` in the same cycle from IDLE moves the block to ARMED only; a further trigger is required.

## Structure
- **Package `acq_pkg`:** the state enum `acq_state_e` (IDLE, ARMED, CAPTURE, DONE).
- **Sub-module `acq_decim`:** the decimation counter. It is loadable with a modulus, advances on enable, and outputs a keep strobe. All other logic stays in the top level.
- **RTL size:** about 150–200 lines.

## Test plan
- **Basic capture:** decim=0, nsamp=8, continuous valid, ramp data starting at 0x10 on the beat after trigger → writes 0x10..0x17 to addresses 0..7; `done` high in the cycle of the address-7 write; `gap`=0.
- **Decimation:** decim=2, nsamp=4, ramp data from 0 → data 0, 3, 6, 9 written to addresses 0..3.
- **Full depth:** nsamp=0 with ADDR_WIDTH=4 → exactly 16 writes, addresses 0..15, no wrap, then DONE.
- **Valid gaps:** `s_tvalid` toggling 1,0,1,0 with decim=0, nsamp=4 → 4 writes of the valid beats only, spanning 8 cycles; `gap`=1. A subsequent `arm` clears `gap`.
- **Abort:** `abort` after 3 writes with nsamp=10 → exactly 3 writes, state IDLE, `done`=0. A later `trigger` without `arm` produces no writes.
- **Reset mid-capture and stray trigger:** `rst` during CAPTURE → all outputs 0 next cycle and `s_tready`=0 for that cycle. A trigger while in IDLE is ignored.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types for the triggered ADC capture engine.
package acq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } acq_state_e;

endpackage

// File: rtl/acq_capture_if.sv
// ADC stream input and BRAM write port of the capture engine, bundled as one bus.
interface acq_capture_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
) ();

    logic                  s_tvalid;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tready;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;

    // The master side produces the stream and observes the BRAM writes.
    modport master (
        output s_tvalid,
        output s_tdata,
        input  s_tready,
        input  bram_we,
        input  bram_addr,
        input  bram_din
    );

    modport slave (
        input  s_tvalid,
        input  s_tdata,
        output s_tready,
        output bram_we,
        output bram_addr,
        output bram_din
    );

endinterface

// File: rtl/acq_decim.sv
// Decimation counter: keep strobe is high on the first of every modulus+1 enabled beats.
module acq_decim #(
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DECIM_WIDTH-1:0] modulus,
    input  logic                   enable,
    output logic                   keep
);

    localparam logic [DECIM_WIDTH-1:0] CNT_ONE = DECIM_WIDTH'(1);

    logic [DECIM_WIDTH-1:0] mod_q, mod_d;
    logic [DECIM_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        mod_d = mod_q;
        cnt_d = cnt_q;
        if (load) begin
            mod_d = modulus;
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == mod_q) ? '0 : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mod_q <= '0;
            cnt_q <= '0;
        end else begin
            mod_q <= mod_d;
            cnt_q <= cnt_d;
        end
    end

    assign keep = (cnt_q == '0);

endmodule

// File: rtl/acq_capture.sv
// Triggered capture engine: after arm and trigger, writes nsamp decimated stream beats to BRAM from address 0.
module acq_capture
    import acq_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 12,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    acq_capture_if.slave           bus,
    input  logic                   arm,
    input  logic                   trigger,
    input  logic                   abort,
    input  logic [DECIM_WIDTH-1:0] decim,
    input  logic [ADDR_WIDTH-1:0]  nsamp,
    output logic                   busy,
    output logic                   done,
    output logic                   gap
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    acq_state_e state_q, state_d;

    logic                  s_tready_q, s_tready_d;
    logic                  bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] nsamp_q, nsamp_d;
    logic                  gap_q, gap_d;

    logic                  accept;
    logic                  in_capture;
    logic                  arm_ok;
    logic                  trig_ok;
    logic                  beat_step;
    logic                  keep;
    logic                  write_now;
    logic                  last_write;
    logic [ADDR_WIDTH-1:0] last_addr;

    assign accept     = bus.s_tvalid & s_tready_q;
    assign in_capture = (state_q == CAPTURE);
    assign arm_ok     = arm & ~abort & ((state_q == IDLE) | (state_q == DONE));
    assign trig_ok    = trigger & ~abort & (state_q == ARMED);
    assign beat_step  = in_capture & accept & ~abort;
    assign write_now  = beat_step & keep;

    // nsamp of zero wraps to all-ones here, giving the full 2^ADDR_WIDTH depth.
    assign last_addr  = nsamp_q - ADDR_ONE;
    assign last_write = write_now & (wr_addr_q == last_addr);

    acq_decim #(
        .DECIM_WIDTH(DECIM_WIDTH)
    ) u_decim (
        .clk    (clk),
        .rst    (rst),
        .load   (trig_ok),
        .modulus(decim),
        .enable (beat_step),
        .keep   (keep)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (arm)        state_d = ARMED;
                ARMED:   if (trigger)    state_d = CAPTURE;
                CAPTURE: if (last_write) state_d = DONE;
                DONE:    if (arm)        state_d = ARMED;
                default:                 state_d = IDLE;
            endcase
        end
    end

    // Write port, address/length bookkeeping and the sticky gap flag.
    always_comb begin
        s_tready_d  = 1'b1;
        bram_we_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        wr_addr_d   = wr_addr_q;
        nsamp_d     = nsamp_q;
        gap_d       = gap_q;

        if (trig_ok) begin
            nsamp_d   = nsamp;
            wr_addr_d = '0;
        end

        if (write_now) begin
            bram_we_d   = 1'b1;
            bram_addr_d = wr_addr_q;
            bram_din_d  = bus.s_tdata;
            wr_addr_d   = wr_addr_q + ADDR_ONE;
        end

        if (arm_ok) begin
            gap_d = 1'b0;
        end else if (in_capture && !bus.s_tvalid) begin
            gap_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_tready_q  <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            wr_addr_q   <= '0;
            nsamp_q     <= '0;
            gap_q       <= 1'b0;
        end else begin
            s_tready_q  <= s_tready_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            wr_addr_q   <= wr_addr_d;
            nsamp_q     <= nsamp_d;
            gap_q       <= gap_d;
        end
    end

    always_comb begin
        busy = (state_q == ARMED) || (state_q == CAPTURE);
        done = (state_q == DONE);
    end

    assign bus.s_tready  = s_tready_q;
    assign bus.bram_we   = bram_we_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_din  = bram_din_q;
    assign gap           = gap_q;

endmodule

// File: tb/tb_acq_capture.sv
// Scoreboard bench for acq_capture: a small model predicts BRAM writes, a monitor pops and compares them.
module tb_acq_capture;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int DCW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           arm;
    logic           trigger;
    logic           abort;
    logic [DCW-1:0] decim;
    logic [AW-1:0]  nsamp;
    logic           busy;
    logic           done;
    logic           gap;

    acq_capture_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    acq_capture #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DECIM_WIDTH(DCW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .arm    (arm),
        .trigger(trigger),
        .abort  (abort),
        .decim  (decim),
        .nsamp  (nsamp),
        .busy   (busy),
        .done   (done),
        .gap    (gap)
    );

    always #5 clk = ~clk;

    int  cmp_count  = 0;
    int  fail_count = 0;
    wr_t exp_q[$];

    // Reference model of the capture engine's write sequence.
    bit  m_armed     = 0;
    bit  m_capturing = 0;
    int  m_cnt       = 0;
    int  m_decim     = 0;
    int  m_addr      = 0;
    int  m_left      = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        cmp_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Every step lands just after the falling edge, after the monitor has run.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data);
        wr_t w;
        bus.s_tvalid = valid;
        bus.s_tdata  = data;
        if (m_capturing && valid) begin
            if (m_cnt == 0) begin
                w.addr = AW'(m_addr);
                w.data = data;
                exp_q.push_back(w);
                m_addr++;
                m_left--;
                if (m_left == 0) m_capturing = 0;
            end
            m_cnt = (m_cnt == m_decim) ? 0 : m_cnt + 1;
        end
        cycle();
        checkOutput("sb_lag", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_arm();
        arm          = 1'b1;
        bus.s_tvalid = 1'b0;
        if (!m_capturing) m_armed = 1;
        cycle();
        arm = 1'b0;
    endtask

    task automatic do_trigger(input int d, input int n);
        decim        = DCW'(d);
        nsamp        = AW'(n);
        trigger      = 1'b1;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = 64'h0F;
        if (m_armed) begin
            m_armed     = 0;
            m_capturing = 1;
            m_cnt       = 0;
            m_addr      = 0;
            m_decim     = d;
            m_left      = (n == 0) ? (1 << AW) : n;
        end
        cycle();
        trigger = 1'b0;
    endtask

    task automatic run_capture(input bit toggle_valid, input logic [DW-1:0] base);
        for (int i = 0; i < 100 && m_capturing; i++) begin
            applyStimulus(toggle_valid ? ((i % 2) == 0) : 1'b1, base + DW'(i));
            checkOutput("cap_done", 64'(done), 64'(!m_capturing));
            checkOutput("cap_busy", 64'(busy), 64'(m_capturing));
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.bram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_we", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_addr", 64'(bus.bram_addr), 64'(e.addr));
                checkOutput("wr_data", bus.bram_din, e.data);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        arm          = 1'b0;
        trigger      = 1'b0;
        abort        = 1'b0;
        decim        = '0;
        nsamp        = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        repeat (3) cycle();
        checkOutput("rst_tready", 64'(bus.s_tready), 64'd0);
        checkOutput("rst_we",     64'(bus.bram_we),  64'd0);
        checkOutput("rst_busy",   64'(busy),         64'd0);
        checkOutput("rst_done",   64'(done),         64'd0);
        checkOutput("rst_gap",    64'(gap),          64'd0);
        rst = 1'b0;
        cycle();
        checkOutput("tready_up", 64'(bus.s_tready), 64'd1);

        $display("[TB] stray trigger while idle");
        do_trigger(0, 4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h50 + 64'(i));
        checkOutput("idle_trig_busy", 64'(busy), 64'd0);

        $display("[TB] arm and trigger together, then basic capture");
        arm     = 1'b1;
        trigger = 1'b1;
        m_armed = 1;
        cycle();
        arm     = 1'b0;
        trigger = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 64'h60 + 64'(i));
        checkOutput("armtrig_busy", 64'(busy), 64'd1);
        checkOutput("armtrig_done", 64'(done), 64'd0);
        do_trigger(0, 8);
        run_capture(1'b0, 64'h10);
        checkOutput("basic_gap", 64'(gap), 64'd0);

        $display("[TB] decimation by 3");
        do_arm();
        checkOutput("rearm_busy", 64'(busy), 64'd1);
        do_trigger(2, 4);
        run_capture(1'b0, 64'h0);

        $display("[TB] full depth");
        do_arm();
        do_trigger(0, 0);
        run_capture(1'b0, 64'h100);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h1F0 + 64'(i));
        checkOutput("full_done_hold", 64'(done), 64'd1);

        $display("[TB] valid gaps");
        do_arm();
        do_trigger(0, 4);
        run_capture(1'b1, 64'h200);
        checkOutput("gap_set", 64'(gap), 64'd1);
        do_arm();
        checkOutput("gap_clear", 64'(gap), 64'd0);

        $display("[TB] abort mid-capture");
        do_trigger(0, 10);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h300 + 64'(i));
        abort        = 1'b1;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = 64'h3FF;
        m_capturing  = 0;
        m_armed      = 0;
        cycle();
        abort = 1'b0;
        checkOutput("abort_we",   64'(bus.bram_we), 64'd0);
        checkOutput("abort_busy", 64'(busy),        64'd0);
        checkOutput("abort_done", 64'(done),        64'd0);
        do_trigger(0, 4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h380 + 64'(i));
        checkOutput("abort_trig_busy", 64'(busy), 64'd0);

        $display("[TB] reset mid-capture");
        do_arm();
        do_trigger(0, 8);
        applyStimulus(1'b1, 64'h400);
        applyStimulus(1'b1, 64'h401);
        applyStimulus(1'b0, 64'h402);
        checkOutput("pre_rst_gap", 64'(gap), 64'd1);
        rst          = 1'b1;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = 64'h4FF;
        m_capturing  = 0;
        m_armed      = 0;
        cycle();
        checkOutput("mid_rst_we",     64'(bus.bram_we),   64'd0);
        checkOutput("mid_rst_addr",   64'(bus.bram_addr), 64'd0);
        checkOutput("mid_rst_din",    bus.bram_din,       64'd0);
        checkOutput("mid_rst_tready", 64'(bus.s_tready),  64'd0);
        checkOutput("mid_rst_busy",   64'(busy),          64'd0);
        checkOutput("mid_rst_done",   64'(done),          64'd0);
        checkOutput("mid_rst_gap",    64'(gap),           64'd0);
        rst = 1'b0;
        cycle();
        checkOutput("post_rst_tready", 64'(bus.s_tready), 64'd1);
        do_trigger(0, 4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h480 + 64'(i));
        checkOutput("post_rst_trig_busy", 64'(busy), 64'd0);

        checkOutput("final_drain", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
